// File: rtl/ipq_pkg.sv
// rtl/ipq_pkg.sv - shared types and constants for the instruction prefetch queue
//
// Purpose : fetch FSM state encoding, reset PC, PC increment and the default
//           queue depth used by inst_prefetch_queue and its testbench.
// Ports   : none (package).
package ipq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no request outstanding
      REQ  = 2'd1,   // request outstanding, response will be kept
      DROP = 2'd2    // request outstanding, response will be discarded
   } ipq_state_e;

   localparam int PC_RESET      = 0;
   localparam int PC_STEP       = 4;
   localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous circular-buffer FIFO with clear
//
// Purpose : DEPTH-entry queue (DEPTH a power of two). The head entry is read
//           straight from storage, so rdata_o is a registered value. Storage
//           is zeroed on reset so the head is never X.
// Ports   : clk, rst (sync, active-high)
//           clear_i   - drop all entries (wins over push/pop)
//           push_i    - write wdata_i at the tail
//           pop_i     - advance the head (ignored when empty)
//           wdata_i   - tail data
//           rdata_o   - head data
//           full_o / empty_o / count_o - occupancy
module sync_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             pop_eff;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign pop_eff = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_eff) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !clear_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // The producer gates its requests on occupancy; a push into a full
   // queue means that gating is broken.
   always_ff @(posedge clk) begin
      if (!rst && !clear_i) assert (!(push_i && full_o));
   end

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - instruction prefetch stage with redirect flush
//
// Purpose : owns the fetch PC, issues word fetches with a req/ack handshake
//           that tolerates any memory latency, and queues {inst, pc+4} for
//           the IF/ID register. A redirect flushes the queue; a response
//           still in flight at redirect time is waited for and discarded.
// Option  : IPQ_PERF_EN adds perf_fetch_cnt / perf_drop_cnt (saturating).
// Ports   : clk, rst (sync, active-high)
//           redirect, redirect_pc      - flush and restart from ID
//           mem_req, mem_addr          - fetch request (held until ack)
//           mem_ack, mem_rdata         - fetch response
//           out_valid, out_inst,
//           out_pc_plus4, out_ready    - queue head towards IF/ID
//           perf_fetch_cnt,
//           perf_drop_cnt              - accepted / discarded acks (option)
module inst_prefetch_queue
   import ipq_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc_plus4,
   input  logic              out_ready
`ifdef IPQ_PERF_EN
   ,
   output logic [15:0]       perf_fetch_cnt,
   output logic [15:0]       perf_drop_cnt
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int FW    = ADDR_W + DATA_W;

   ipq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

   logic              push;
   logic              pop;
   logic              ack_drop;
   logic              empty;
   logic              unused_full;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [FW-1:0]     head;

   // Only a response to a request that is still wanted is queued.
   assign push       = (state_q == REQ) && mem_ack && !redirect;
   assign pop        = out_valid && out_ready && !redirect;
   assign count_next = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      ack_drop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!redirect && (count_next < CNT_W'(DEPTH))) state_d = REQ;
         end
         REQ: begin
            if (redirect) begin
               if (mem_ack) begin
                  ack_drop = 1'b1;
                  state_d  = IDLE;
               end else begin
                  // Memory still owes us this word; keep its address on
                  // the bus until it arrives.
                  drop_addr_d = fetch_pc_q;
                  state_d     = DROP;
               end
            end else if (mem_ack) begin
               fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
               if (count_next >= CNT_W'(DEPTH)) state_d = IDLE;
            end
         end
         DROP: begin
            if (mem_ack) begin
               ack_drop = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect) fetch_pc_d = redirect_pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= ADDR_W'(PC_RESET);
         drop_addr_q <= ADDR_W'(PC_RESET);
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   assign mem_req  = (state_q == REQ) || (state_q == DROP);
   assign mem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (redirect),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({mem_rdata, fetch_pc_q + ADDR_W'(PC_STEP)}),
      .rdata_o (head),
      .full_o  (unused_full),
      .empty_o (empty),
      .count_o (count)
   );

   assign out_valid    = !empty;
   assign out_inst     = head[FW-1:ADDR_W];
   assign out_pc_plus4 = head[ADDR_W-1:0];

`ifdef IPQ_PERF_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] drop_cnt_q;

   // Counters survive redirects; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (push && (fetch_cnt_q != 16'hFFFF))    fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (ack_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q  <= drop_cnt_q + 16'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_drop_cnt  = drop_cnt_q;
`else
   // Without counters the drop strobe has no consumer.
   logic unused_ack_drop;
   assign unused_ack_drop = ack_drop;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - self-checking bench for inst_prefetch_queue
module tb_inst_prefetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc_plus4;
   logic        out_ready = 1'b0;
`ifdef IPQ_PERF_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_drop_cnt;
`endif

   always #5 clk = ~clk;

   inst_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_inst     (out_inst),
      .out_pc_plus4 (out_pc_plus4),
      .out_ready    (out_ready)
`ifdef IPQ_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_drop_cnt  (perf_drop_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: an ordered list of words the consumer should see,
   // the next address the stage should fetch, and whether a response is
   // owed by memory that must be thrown away.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc = '0;
   logic [31:0] m_held = '0;
   bit          m_pending = 1'b0;
   int          m_fetch = 0;
   int          m_drop = 0;
   int          stall = 0;

   // Inputs applied during the cycle that the next edge will sample.
   bit          p_rst = 1'b1, p_req = 1'b0, p_ack = 1'b0, p_redir = 1'b0, p_ready = 1'b0;
   logic [31:0] p_rdata = '0, p_rpc = '0;

   // Stimulus knobs and memory model.
   int          lat_min = 0, lat_max = 0, ready_pct = 100, redir_pct = 0;
   bit          scramble = 1'b0;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = '0;
   int          mem_wait = 0;
   int          ack_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return scramble ? ((a ^ 32'hC3A5_5A3C) + 32'h0000_1357) : a;
   endfunction

   task automatic step();
      bit acc;
      p_rst = rst;
      @(posedge clk);
      #1;
      if (p_rst) begin
         mq.delete();
         m_pc      = '0;
         m_held    = '0;
         m_pending = 1'b0;
         m_fetch   = 0;
         m_drop    = 0;
      end else begin
         acc = p_ack && !p_redir && !m_pending;
         if (acc && m_fetch < 65535) m_fetch++;
         if (p_ack && !acc && m_drop < 65535) m_drop++;
         if (!p_redir && p_ready && mq.size() > 0) void'(mq.pop_front());
         if (acc) mq.push_back('{inst: p_rdata, pc4: m_pc + 32'd4});
         if (p_redir) mq.delete();
         if (p_redir) begin
            if (p_req && !p_ack) begin
               if (!m_pending) m_held = m_pc;
               m_pending = 1'b1;
            end else begin
               m_pending = 1'b0;
            end
         end else if (p_ack) begin
            m_pending = 1'b0;
         end
         if (p_redir)  m_pc = p_rpc;
         else if (acc) m_pc = m_pc + 32'd4;
         check("queue_bound", mq.size() > DEPTH, 0);
      end

      check("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check("out_inst", out_inst, mq[0].inst);
         check("out_pc_plus4", out_pc_plus4, mq[0].pc4);
      end
      if (m_pending) check("drop_req_held", mem_req, 1);
      if (mem_req) check("mem_addr", mem_addr, m_pending ? m_held : m_pc);
      if (!p_rst && !p_redir && !mem_req && mq.size() < DEPTH) stall++;
      else stall = 0;
      check("no_stall", stall > 1, 0);

      if (rst) begin
         mem_ack   = 1'b0;
         redirect  = 1'b0;
         out_ready = 1'b0;
         mem_wait  = lat_min;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (mem_req) begin
            if (mem_wait <= 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_word(mem_addr);
               ack_cnt++;
               mem_wait  = $urandom_range(lat_max, lat_min);
            end else begin
               mem_wait--;
            end
         end
         out_ready   = ($urandom_range(99, 0) < ready_pct);
         redirect    = force_redir || ($urandom_range(99, 0) < redir_pct);
         redirect_pc = force_redir ? force_pc :
                       (($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC));
         force_redir = 1'b0;
      end
      p_req   = mem_req;
      p_ack   = mem_ack;
      p_rdata = mem_rdata;
      p_redir = redirect;
      p_rpc   = redirect_pc;
      p_ready = out_ready;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
   endtask

   initial begin
      int  vcnt;
      bit  found;

      // Reset state.
      do_reset();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_inst", out_inst, 0);
      check("rst_out_pc_plus4", out_pc_plus4, 0);

      // Zero-wait memory, consumer always ready: one word per cycle.
      lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0; scramble = 1'b0;
      rst = 1'b0;
      step();
      check("first_req", mem_req, 1);
      check("first_addr", mem_addr, 0);
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid) vcnt++;
         if (i == 0) begin
            check("t1_inst0", out_inst, 32'h0);
            check("t1_pc4_0", out_pc_plus4, 32'h4);
         end
         if (i == 2) check("t1_inst2", out_inst, 32'h8);
      end
      check("t1_sustain", vcnt, 20);

      // Consumer stalled: queue fills to DEPTH and fetching stops.
      ready_pct = 0;
      do_reset();
      ack_cnt = 0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("t2_pushes", ack_cnt, DEPTH);
      check("t2_req_off", mem_req, 0);
      check("t2_valid", out_valid, 1);
      ready_pct = 100;
      for (int i = 0; i < 6; i++) begin
         step();
         if (mem_req) break;
      end
      check("t2_resume_req", mem_req, 1);
      check("t2_resume_addr", mem_addr, 4 * DEPTH);

      // 3-cycle latency, redirect while waiting.
      lat_min = 3; lat_max = 3;
      do_reset();
      rst = 1'b0;
      step();
      force_redir = 1'b1; force_pc = 32'h100;
      step();
      step();
      check("t3_drop_req", mem_req, 1);
      check("t3_drop_addr", mem_addr, 0);
      step();
      step();
      check("t3_discard_valid", out_valid, 0);
      check("t3_idle_req", mem_req, 0);
      check("t3_next_addr", mem_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (out_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("t3_got_word", found, 1);
      check("t3_first_pc4", out_pc_plus4, 32'h104);

      // Redirect coinciding with ack and pop.
      lat_min = 0; lat_max = 0;
      do_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      force_redir = 1'b1; force_pc = 32'h200;
      step();
      check("t4_pre_req", mem_req, 1);
      check("t4_pre_valid", out_valid, 1);
      step();
      check("t4_empty", out_valid, 0);
      check("t4_no_req", mem_req, 0);
      check("t4_addr", mem_addr, 32'h200);

      // Reset mid-request with the queue half full.
      ready_pct = 0;
      do_reset();
      ack_cnt = 0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ack_cnt >= 2) break;
      end
      mem_wait = 50; lat_min = 50; lat_max = 50;
      step();
      step();
      check("t5_mid_req", mem_req, 1);
      check("t5_half_full", out_valid, 1);
      lat_min = 0; lat_max = 0;
      rst = 1'b1;
      step();
      check("t5_rst_req", mem_req, 0);
      check("t5_rst_addr", mem_addr, 0);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_inst", out_inst, 0);
      check("t5_rst_pc4", out_pc_plus4, 0);
      rst = 1'b0;
      step();
      check("t5_restart_req", mem_req, 1);
      check("t5_restart_addr", mem_addr, 0);

      // Randomized traffic against the model.
      lat_min = 0; lat_max = 3; ready_pct = 70; redir_pct = 4; scramble = 1'b1;
      do_reset();
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) step();
`ifdef IPQ_PERF_EN
      check("perf_fetch", perf_fetch_cnt, m_fetch);
      check("perf_drop", perf_drop_cnt, m_drop);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
